// File: rtl/alien_formation_pkg.sv
// -----------------------------------------------------------------------------
// alien_formation_pkg
//   Shared geometry, speed constants and the formation state type for the
//   enemy-grid block and its helpers.
//   No ports; imported with "import alien_formation_pkg::*".
// -----------------------------------------------------------------------------
package alien_formation_pkg;

    // Grid shape
    localparam int unsigned NUM_ROWS   = 10;
    localparam int unsigned NUM_COLS   = 6;
    localparam int unsigned NUM_ALIENS = NUM_ROWS * NUM_COLS;

    // Alien geometry, pixels
    localparam int unsigned ENEMY_W   = 32;
    localparam int unsigned ENEMY_H   = 28;
    localparam int unsigned SPACING_X = 50;
    localparam int unsigned SPACING_Y = 16;
    localparam int unsigned PITCH_X   = ENEMY_W + SPACING_X;
    localparam int unsigned PITCH_Y   = ENEMY_H + SPACING_Y;

    // Playfield
    localparam int unsigned HRES      = 1280;
    localparam int unsigned HSTART    = 419;
    localparam int unsigned VSTART    = 108;
    localparam int unsigned DROP_STEP = 32;
    localparam int unsigned FLOOR_Y   = 684;

    // Speed control
    localparam int unsigned BASE_SPEED     = 1;
    localparam int unsigned FORM_MAX_SPEED = 4;
    localparam int unsigned SPEEDUP_STEP   = 8;

    typedef enum logic [1:0] {
        MARCH,
        DROP,
        CLEAR,
        INVADED
    } form_state_t;

    // Starting speed of a wave: grows with the level, capped at the ceiling.
    function automatic logic [2:0] wave_speed(input logic [3:0] lvl);
        logic [4:0] s;
        s = 5'(BASE_SPEED) + {1'b0, lvl};
        if (s > 5'(FORM_MAX_SPEED)) begin
            s = 5'(FORM_MAX_SPEED);
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/alien_formation_if.sv
// -----------------------------------------------------------------------------
// alien_formation_if
//   Bundles the formation's control, kill-request and renderer-facing signals.
//   master : game control / collision side (drives frame_tick, restart, kill_*)
//   slave  : the formation itself (drives kill_hit, position, bitmap, status)
//   Signals:
//     frame_tick, restart        one-cycle control pulses
//     kill_valid/kill_row/col    kill request, answered by kill_hit next cycle
//     form_x/form_y              anchor of alien[0][0]
//     alive, alive_count         bitmap (row*NUM_COLS+col) and population
//     dir_right, speed, level    motion status and wave counter
//     wave_clear, invaded        status to game control
// -----------------------------------------------------------------------------
interface alien_formation_if;
    import alien_formation_pkg::*;

    logic                  frame_tick;
    logic                  restart;
    logic                  kill_valid;
    logic [3:0]            kill_row;
    logic [2:0]            kill_col;
    logic                  kill_hit;
    logic [10:0]           form_x;
    logic [9:0]            form_y;
    logic [NUM_ALIENS-1:0] alive;
    logic [6:0]            alive_count;
    logic                  dir_right;
    logic [2:0]            speed;
    logic [3:0]            level;
    logic                  wave_clear;
    logic                  invaded;

    modport master (
        output frame_tick, restart, kill_valid, kill_row, kill_col,
        input  kill_hit, form_x, form_y, alive, alive_count,
               dir_right, speed, level, wave_clear, invaded
    );

    modport slave (
        input  frame_tick, restart, kill_valid, kill_row, kill_col,
        output kill_hit, form_x, form_y, alive, alive_count,
               dir_right, speed, level, wave_clear, invaded
    );

endinterface

// File: rtl/alien_formation_extent.sv
// -----------------------------------------------------------------------------
// alien_extent
//   Combinational extent finder over the alive bitmap.
//   Ports:
//     alive   in  NUM_ALIENS  bitmap, bit index row*NUM_COLS+col
//     lcol    out 3           leftmost column holding a live alien
//     rcol    out 3           rightmost column holding a live alien
//     lowrow  out 4           lowest (highest-index) row holding a live alien
//   With an empty bitmap all outputs are 0.
// -----------------------------------------------------------------------------
module alien_extent
    import alien_formation_pkg::*;
(
    input  logic [NUM_ALIENS-1:0] alive,
    output logic [2:0]            lcol,
    output logic [2:0]            rcol,
    output logic [3:0]            lowrow
);

    logic [NUM_COLS-1:0] col_any;
    logic [NUM_ROWS-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if (alive[r*NUM_COLS + c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end

        // Descending scan so the lowest occupied column is written last.
        lcol = '0;
        for (int unsigned c = NUM_COLS; c > 0; c--) begin
            if (col_any[c-1]) begin
                lcol = 3'(c - 1);
            end
        end

        rcol = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (col_any[c]) begin
                rcol = 3'(c);
            end
        end

        lowrow = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (row_any[r]) begin
                lowrow = 4'(r);
            end
        end
    end

endmodule

// File: rtl/alien_formation.sv
// -----------------------------------------------------------------------------
// alien_formation
//   Owns the enemy grid: anchor position, alive bitmap, march/drop FSM,
//   kill-driven speed-up and the per-level starting speed.
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous active-high reset
//     bus   alien_formation_if.slave (control pulses, kill requests, grid state)
// -----------------------------------------------------------------------------
module alien_formation
    import alien_formation_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alien_formation_if.slave bus
);

    localparam logic [11:0] PITCH_X12   = 12'(PITCH_X);
    localparam logic [11:0] PITCH_Y12   = 12'(PITCH_Y);
    localparam logic [11:0] RIGHT_OFF12 = 12'(ENEMY_W - 1);
    localparam logic [11:0] ENEMY_H12   = 12'(ENEMY_H);
    localparam logic [11:0] HRES_MAX12  = 12'(HRES - 1);
    localparam logic [11:0] FLOOR_Y12   = 12'(FLOOR_Y);

    form_state_t           state, state_n;
    logic [10:0]           form_x, form_x_n;
    logic [9:0]            form_y, form_y_n;
    logic [NUM_ALIENS-1:0] alive, alive_n;
    logic [6:0]            alive_count, alive_count_n;
    logic                  dir_right, dir_right_n;
    logic [2:0]            speed, speed_n;
    logic [3:0]            level, level_n;
    logic [3:0]            step_cnt, step_cnt_n;
    logic                  kill_hit, kill_hit_n;
    logic                  wave_clear, wave_clear_n;

    logic [2:0]  lcol;
    logic [2:0]  rcol;
    logic [3:0]  lowrow;

    logic [11:0] nx;
    logic [11:0] right_px;
    logic [11:0] left_px;
    logic [11:0] bottom;
    logic        edge_hit;
    logic        floor_hit;
    logic [5:0]  kill_idx;
    logic        kill_in_range;
    logic        kill_ok;

    // Extents come from the registered bitmap, so a same-cycle kill never
    // changes the edge test of that frame.
    alien_extent u_extent (
        .alive  (alive),
        .lcol   (lcol),
        .rcol   (rcol),
        .lowrow (lowrow)
    );

    // Geometry and kill qualification
    always_comb begin
        nx = dir_right ? ({1'b0, form_x} + {9'b0, speed})
                       : ({1'b0, form_x} - {9'b0, speed});
        right_px  = nx + ({9'b0, rcol} * PITCH_X12) + RIGHT_OFF12;
        left_px   = nx + ({9'b0, lcol} * PITCH_X12);
        // 12-bit signed view: a step past x=0 shows up as a negative left pixel.
        edge_hit  = ($signed(right_px) > $signed(HRES_MAX12)) || left_px[11];

        bottom    = {2'b0, form_y} + ({8'b0, lowrow} * PITCH_Y12) + ENEMY_H12;
        floor_hit = (bottom >= FLOOR_Y12);

        kill_in_range = (bus.kill_row < 4'(NUM_ROWS)) && (bus.kill_col < 3'(NUM_COLS));
        // Wraps for out-of-range targets, but those are masked by kill_in_range.
        kill_idx      = (6'(bus.kill_row) * 6'(NUM_COLS)) + 6'(bus.kill_col);
        kill_ok       = bus.kill_valid && kill_in_range &&
                        ((state == MARCH) || (state == DROP)) && alive[kill_idx];
    end

    // Next-state and datapath update
    always_comb begin
        state_n       = state;
        form_x_n      = form_x;
        form_y_n      = form_y;
        alive_n       = alive;
        alive_count_n = alive_count;
        dir_right_n   = dir_right;
        speed_n       = speed;
        level_n       = level;
        step_cnt_n    = step_cnt;
        kill_hit_n    = 1'b0;
        wave_clear_n  = 1'b0;

        if (bus.restart) begin
            state_n       = MARCH;
            form_x_n      = 11'(HSTART);
            form_y_n      = 10'(VSTART);
            alive_n       = '1;
            alive_count_n = 7'(NUM_ALIENS);
            dir_right_n   = 1'b1;
            step_cnt_n    = '0;
            if ((state == CLEAR) && (level != 4'hF)) begin
                level_n = level + 4'd1;
            end
            speed_n = wave_speed(level_n);
        end else begin
            unique case (state)
                MARCH: begin
                    if (bus.frame_tick) begin
                        if (edge_hit) begin
                            form_y_n    = form_y + 10'(DROP_STEP);
                            dir_right_n = ~dir_right;
                            state_n     = DROP;
                        end else begin
                            form_x_n = nx[10:0];
                        end
                    end
                end
                DROP: begin
                    // form_y already holds the dropped value here.
                    if (floor_hit) begin
                        state_n = INVADED;
                    end else if (bus.frame_tick) begin
                        state_n = MARCH;
                    end
                end
                default: ;
            endcase

            if (kill_ok) begin
                alive_n[kill_idx] = 1'b0;
                alive_count_n     = alive_count - 7'd1;
                kill_hit_n        = 1'b1;
                if (step_cnt == 4'(SPEEDUP_STEP - 1)) begin
                    step_cnt_n = '0;
                    if (speed < 3'(FORM_MAX_SPEED)) begin
                        speed_n = speed + 3'd1;
                    end
                end else begin
                    step_cnt_n = step_cnt + 4'd1;
                end
                // Killing the last alien overrides any drop/invade transition.
                if (alive_count == 7'd1) begin
                    state_n      = CLEAR;
                    wave_clear_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MARCH;
            form_x      <= 11'(HSTART);
            form_y      <= 10'(VSTART);
            alive       <= '1;
            alive_count <= 7'(NUM_ALIENS);
            dir_right   <= 1'b1;
            speed       <= 3'(BASE_SPEED);
            level       <= '0;
            step_cnt    <= '0;
            kill_hit    <= 1'b0;
            wave_clear  <= 1'b0;
        end else begin
            state       <= state_n;
            form_x      <= form_x_n;
            form_y      <= form_y_n;
            alive       <= alive_n;
            alive_count <= alive_count_n;
            dir_right   <= dir_right_n;
            speed       <= speed_n;
            level       <= level_n;
            step_cnt    <= step_cnt_n;
            kill_hit    <= kill_hit_n;
            wave_clear  <= wave_clear_n;
        end
    end

    assign bus.kill_hit    = kill_hit;
    assign bus.form_x      = form_x;
    assign bus.form_y      = form_y;
    assign bus.alive       = alive;
    assign bus.alive_count = alive_count;
    assign bus.dir_right   = dir_right;
    assign bus.speed       = speed;
    assign bus.level       = level;
    assign bus.wave_clear  = wave_clear;
    assign bus.invaded     = (state == INVADED);

endmodule

// File: tb/tb_alien_formation.sv
// -----------------------------------------------------------------------------
// tb_alien_formation
//   Directed bench for alien_formation. A behavioural model of the grid is
//   advanced alongside each applied cycle; a compare process checks every DUT
//   output against it after each clock, and hand-computed literals pin key
//   points of the scenario.
// -----------------------------------------------------------------------------
module tb_alien_formation;
    import alien_formation_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alien_formation_if bus ();

    alien_formation dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    // Behavioural model
    int m_x, m_y, m_cnt, m_speed, m_level, m_steps;
    bit m_dir, m_hit, m_wclear, m_dropping, m_cleared, m_invaded;
    bit m_alive [60];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_wave_reload();
        m_x = 419; m_y = 108; m_cnt = 60; m_dir = 1'b1; m_steps = 0; m_dropping = 1'b0;
        for (int i = 0; i < 60; i++) m_alive[i] = 1'b1;
    endtask

    task automatic model_apply(input bit r, input bit t, input bit rs,
                               input bit kv, input int kr, input int kc);
        int lc, rc, lr, nx;
        bit live;
        m_hit = 1'b0;
        m_wclear = 1'b0;
        if (r) begin
            model_wave_reload();
            m_level = 0; m_speed = 1; m_cleared = 1'b0; m_invaded = 1'b0;
            return;
        end
        if (rs) begin
            if (m_cleared && m_level < 15) m_level++;
            model_wave_reload();
            m_speed = (1 + m_level > 4) ? 4 : 1 + m_level;
            m_cleared = 1'b0; m_invaded = 1'b0;
            return;
        end
        lc = 99; rc = -1; lr = -1;
        for (int i = 0; i < 60; i++) begin
            if (m_alive[i]) begin
                if (i % 6 < lc) lc = i % 6;
                if (i % 6 > rc) rc = i % 6;
                if (i / 6 > lr) lr = i / 6;
            end
        end
        live = !m_cleared && !m_invaded;
        if (live) begin
            if (!m_dropping) begin
                if (t) begin
                    nx = m_dir ? m_x + m_speed : m_x - m_speed;
                    if (nx + rc * 82 + 31 > 1279 || nx + lc * 82 < 0) begin
                        m_y += 32; m_dir = !m_dir; m_dropping = 1'b1;
                    end else begin
                        m_x = nx;
                    end
                end
            end else begin
                if (m_y + lr * 44 + 28 >= 684) begin
                    m_dropping = 1'b0; m_invaded = 1'b1;
                end else if (t) begin
                    m_dropping = 1'b0;
                end
            end
            if (kv && kr < 10 && kc < 6 && m_alive[kr * 6 + kc]) begin
                m_alive[kr * 6 + kc] = 1'b0;
                m_cnt--; m_hit = 1'b1; m_steps++;
                if (m_steps == 8) begin
                    m_steps = 0;
                    if (m_speed < 4) m_speed++;
                end
                if (m_cnt == 0) begin
                    m_cleared = 1'b1; m_dropping = 1'b0; m_invaded = 1'b0; m_wclear = 1'b1;
                end
            end
        end
    endtask

    // Compare process: every output, every cycle once stimulus has started.
    always @(posedge clk) begin : cmp
        logic [63:0] ea;
        #1;
        if (chk_en) begin
            ea = '0;
            for (int i = 0; i < 60; i++) ea[i] = m_alive[i];
            chk("form_x",      64'(bus.form_x),      64'(m_x));
            chk("form_y",      64'(bus.form_y),      64'(m_y));
            chk("alive",       {4'b0, bus.alive},    ea);
            chk("alive_count", 64'(bus.alive_count), 64'(m_cnt));
            chk("dir_right",   64'(bus.dir_right),   64'(m_dir));
            chk("speed",       64'(bus.speed),       64'(m_speed));
            chk("level",       64'(bus.level),       64'(m_level));
            chk("kill_hit",    64'(bus.kill_hit),    64'(m_hit));
            chk("wave_clear",  64'(bus.wave_clear),  64'(m_wclear));
            chk("invaded",     64'(bus.invaded),     64'(m_invaded));
        end
    end

    task automatic cycle(input bit r, input bit t, input bit rs,
                         input bit kv, input int kr, input int kc);
        @(negedge clk);
        rst            = r;
        bus.frame_tick = t;
        bus.restart    = rs;
        bus.kill_valid = kv;
        bus.kill_row   = 4'(kr);
        bus.kill_col   = 3'(kc);
        model_apply(r, t, rs, kv, kr, kc);
        chk_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic kill(input int kr, input int kc);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, kr, kc);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_restart();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        bus.frame_tick = 1'b0;
        bus.restart    = 1'b0;
        bus.kill_valid = 1'b0;
        bus.kill_row   = '0;
        bus.kill_col   = '0;

        // Reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("rst form_x",  64'(bus.form_x), 64'd419);
        chk("rst form_y",  64'(bus.form_y), 64'd108);
        chk("rst count",   64'(bus.alive_count), 64'd60);
        chk("rst speed",   64'(bus.speed), 64'd1);
        chk("rst invaded", 64'(bus.invaded), 64'd0);

        // March right to the edge, then drop
        for (int i = 0; i < 419; i++) tick();
        chk("march x", 64'(bus.form_x), 64'd838);
        tick();
        chk("edge y",   64'(bus.form_y), 64'd140);
        chk("edge dir", 64'(bus.dir_right), 64'd0);
        chk("edge x",   64'(bus.form_x), 64'd838);
        tick();
        chk("drop hold x", 64'(bus.form_x), 64'd838);
        tick();
        chk("march left x", 64'(bus.form_x), 64'd837);

        // Kills
        kill(0, 0);
        chk("kill hit",   64'(bus.kill_hit), 64'd1);
        chk("kill count", 64'(bus.alive_count), 64'd59);
        kill(0, 0);
        chk("rekill hit", 64'(bus.kill_hit), 64'd0);
        kill(10, 0);
        chk("row10 hit",   64'(bus.kill_hit), 64'd0);
        chk("row10 count", 64'(bus.alive_count), 64'd59);
        kill(0, 6);
        chk("col6 hit", 64'(bus.kill_hit), 64'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3, 2);
        chk("tick+kill x",     64'(bus.form_x), 64'd836);
        chk("tick+kill count", 64'(bus.alive_count), 64'd58);

        // Speed-up and narrowed right extent
        do_restart();
        chk("restart x",     64'(bus.form_x), 64'd419);
        chk("restart level", 64'(bus.level), 64'd0);
        tick();
        for (int r = 0; r < 10; r++) begin
            kill(r, 5);
            if (r == 6) chk("speed after 7", 64'(bus.speed), 64'd1);
            if (r == 7) chk("speed after 8", 64'(bus.speed), 64'd2);
        end
        for (int i = 0; i < 250; i++) tick();
        chk("narrow x",   64'(bus.form_x), 64'd920);
        chk("narrow dir", 64'(bus.dir_right), 64'd1);
        tick();
        chk("narrow drop y", 64'(bus.form_y), 64'd140);
        chk("narrow drop x", 64'(bus.form_x), 64'd920);
        tick();

        // Clear the wave
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 5; c++) kill(r, c);
        end
        chk("clear pulse", 64'(bus.wave_clear), 64'd1);
        chk("clear count", 64'(bus.alive_count), 64'd0);
        idle();
        chk("clear pulse end", 64'(bus.wave_clear), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("clear frozen x", 64'(bus.form_x), 64'd920);
        kill(0, 0);
        chk("clear kill hit", 64'(bus.kill_hit), 64'd0);
        do_restart();
        chk("next level", 64'(bus.level), 64'd1);
        chk("next speed", 64'(bus.speed), 64'd2);
        chk("next x",     64'(bus.form_x), 64'd419);
        chk("next count", 64'(bus.alive_count), 64'd60);

        // Reset mid-wave
        tick();
        kill(4, 4);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5, 5);
        chk("midrst level", 64'(bus.level), 64'd0);
        chk("midrst x",     64'(bus.form_x), 64'd419);
        chk("midrst count", 64'(bus.alive_count), 64'd60);

        // Invasion after five drops
        k = 0;
        while (!m_invaded && k < 6000) begin
            tick();
            k++;
        end
        chk("invaded", 64'(bus.invaded), 64'd1);
        chk("invaded y", 64'(bus.form_y), 64'd268);
        kill(2, 2);
        chk("invaded kill hit", 64'(bus.kill_hit), 64'd0);
        tick();
        chk("invaded frozen y", 64'(bus.form_y), 64'd268);
        do_restart();
        chk("replay invaded", 64'(bus.invaded), 64'd0);
        chk("replay level",   64'(bus.level), 64'd0);
        chk("replay y",       64'(bus.form_y), 64'd108);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
